usart_tx_serialiser: RTL

- Transmit half of the emulated ATMega32A USART: the serialising counterpart to the parallel data-capture registers.
- Takes a byte written to the UDR transmit buffer and shifts it out on txd as an 8N1 asynchronous frame, LSB first.
- Double-buffered: the UDR buffer feeds the transmit shift register.
- Generates the UDRE and TXC status flags and sits between the I/O register decode and the TXD pin model.

---
 rtl/usart_pkg.sv | 8 +
 rtl/usart_tx_serialiser_if.sv | 19 +
 rtl/usart_baud_prescaler.sv | 37 +++
 rtl/usart_tx_serialiser.sv | 72 +++++++
 4 files changed

// File: rtl/usart_pkg.sv
// usart_pkg: shared FSM state encoding, parameter defaults and counter widths for the USART blocks
package usart_pkg;
    localparam int DEF_DATA_BITS  = 8;
    localparam int DEF_OVERSAMPLE = 16;
    localparam int DEF_UBRR_WIDTH = 12;
    localparam int CNT_W          = $clog2(DEF_DATA_BITS);
    typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} state_t;
endpackage

// File: rtl/usart_tx_serialiser_if.sv
// usart_tx_serialiser_if: UDR/control bus (tx_en, ubrr, tx_data, tx_write, txc_clr) in, line/status (txd, udre, txc, busy) out
interface usart_tx_serialiser_if
    import usart_pkg::*;
#(
    parameter int DATA_BITS  = DEF_DATA_BITS,
    parameter int UBRR_WIDTH = DEF_UBRR_WIDTH
);
    logic                  tx_en;
    logic [UBRR_WIDTH-1:0] ubrr;
    logic [DATA_BITS-1:0]  tx_data;
    logic                  tx_write;
    logic                  txc_clr;
    logic                  txd;
    logic                  udre;
    logic                  txc;
    logic                  busy;
    modport master (output tx_en, ubrr, tx_data, tx_write, txc_clr, input txd, udre, txc, busy);
    modport slave (input tx_en, ubrr, tx_data, tx_write, txc_clr, output txd, udre, txc, busy);
endinterface

// File: rtl/usart_baud_prescaler.sv
// usart_baud_prescaler: ubrr down-counter + OVERSAMPLE tick counter; ports clk, clr_n, ubrr, restart in, tick (bit-period end pulse) out
module usart_baud_prescaler
    import usart_pkg::*;
#(
    parameter int UBRR_WIDTH = DEF_UBRR_WIDTH,
    parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
    input  logic                  clk,
    input  logic                  clr_n,
    input  logic [UBRR_WIDTH-1:0] ubrr,
    input  logic                  restart,
    output logic                  tick
);
    localparam int OW = $clog2(OVERSAMPLE);
    logic [UBRR_WIDTH-1:0] cnt;
    logic [OW-1:0]         os_cnt;
    logic                  os_tick;
    logic                  bit_end;
    // each reload of the down-counter is one oversample tick, so ubrr changes land on the next reload
    assign os_tick = cnt == '0;
    assign bit_end = os_tick && os_cnt == OW'(OVERSAMPLE - 1);
    assign tick    = bit_end;
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            cnt    <= '0;
            os_cnt <= '0;
        end else if (restart) begin
            cnt    <= ubrr;
            os_cnt <= '0;
        end else if (os_tick) begin
            cnt    <= ubrr;
            os_cnt <= bit_end ? '0 : os_cnt + 1'b1;
        end else begin
            cnt <= cnt - 1'b1;
        end
    end
endmodule

// File: rtl/usart_tx_serialiser.sv
// usart_tx_serialiser: double-buffered 8N1 transmitter; clk, clr_n plain, bus carries UDR write/control in and txd/udre/txc/busy out
module usart_tx_serialiser
    import usart_pkg::*;
#(
    parameter int DATA_BITS  = DEF_DATA_BITS,
    parameter int OVERSAMPLE = DEF_OVERSAMPLE,
    parameter int UBRR_WIDTH = DEF_UBRR_WIDTH
) (
    input  logic                 clk,
    input  logic                 clr_n,
    usart_tx_serialiser_if.slave bus
);
    localparam int CW = $clog2(DATA_BITS);
    state_t               state, state_d;
    logic [DATA_BITS-1:0] tx_buf, sh;
    logic [CW-1:0]        bit_cnt;
    logic                 full, load, bit_end, done, txc_q, txd_q, busy_q;
    usart_baud_prescaler #(.UBRR_WIDTH(UBRR_WIDTH), .OVERSAMPLE(OVERSAMPLE)) u_prescaler (
        .clk(clk),
        .clr_n(clr_n),
        .ubrr(bus.ubrr),
        .restart(load),
        .tick(bit_end)
    );
    assign bus.txd  = txd_q;
    assign bus.udre = !full;
    assign bus.txc  = txc_q;
    assign bus.busy = busy_q;
    always_ff @(posedge clk) begin
        state <= !clr_n ? IDLE : state_d;
    end
    // transfer happens regardless of tx_en so an already-buffered byte still goes out
    always_comb begin
        load    = full && (state == IDLE || (state == STOP && bit_end));
        state_d = state;
        case (state)
            IDLE:  state_d = load ? START : IDLE;
            START: state_d = bit_end ? DATA : START;
            DATA:  state_d = (bit_end && bit_cnt == CW'(DATA_BITS - 1)) ? STOP : DATA;
            STOP:  state_d = bit_end ? (full ? START : IDLE) : STOP;
        endcase
    end
    // line and status are registered, so they trail the state by one clock
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            tx_buf  <= '0;
            full    <= 1'b0;
            sh      <= '0;
            bit_cnt <= '0;
            done    <= 1'b0;
            txc_q   <= 1'b0;
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            if (load) begin
                sh   <= tx_buf;
                full <= 1'b0;
            end else begin
                if (bus.tx_write && bus.tx_en && !full) begin
                    tx_buf <= bus.tx_data;
                    full   <= 1'b1;
                end
                if (state == DATA && bit_end) sh <= sh >> 1;
            end
            bit_cnt <= state != DATA ? '0 : bit_cnt + CW'(bit_end);
            done    <= state == STOP && bit_end && !full;
            txc_q   <= done || (txc_q && !bus.txc_clr);
            txd_q   <= state == START ? 1'b0 : state == DATA ? sh[0] : 1'b1;
            busy_q  <= state != IDLE;
        end
    end
endmodule
